// File: rtl/i4004_bus_pkg.sv
// Shared constants and types for the MCS-4 bus initiator: phase encoding,
// opcode fields and the latched instruction record.
package i4004_bus_pkg;

    localparam logic [2:0] PH_A1 = 3'd0;
    localparam logic [2:0] PH_A2 = 3'd1;
    localparam logic [2:0] PH_A3 = 3'd2;
    localparam logic [2:0] PH_M1 = 3'd3;
    localparam logic [2:0] PH_M2 = 3'd4;
    localparam logic [2:0] PH_X1 = 3'd5;
    localparam logic [2:0] PH_X2 = 3'd6;
    localparam logic [2:0] PH_X3 = 3'd7;

    localparam logic [3:0] OPR_SRC = 4'h2;
    localparam logic [3:0] OPR_IO  = 4'hE;
    localparam logic [3:0] OPR_ACC = 4'hF;
    localparam logic [3:0] OPA_DCL = 4'hD;

    typedef struct packed {
        logic [3:0] opr;
        logic [3:0] opa;
        logic [7:0] operand;
        logic [3:0] acc;
    } instr_t;

    localparam instr_t NOP_INSTR = '0;

    function automatic logic [3:0] bank_sel(input logic [1:0] sel);
        return 4'b0001 << sel;
    endfunction

endpackage

// File: rtl/i4004_phase_seq.sv
// Phase sequencer: sub-counter within a phase plus the 8-phase counter.
// Exposes both the current and the upcoming state so outputs can be registered.
module i4004_phase_seq
    import i4004_bus_pkg::*;
#(
    parameter int PHASE_CYCLES = 4
) (
    input  logic       sysclk,
    input  logic       reset_n,
    output logic [2:0] phase,
    output logic       last_tick,
    output logic [2:0] nxt_phase,
    output logic       nxt_last
);

    localparam int SW = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
    localparam logic [SW-1:0] SUB_LAST = SW'(PHASE_CYCLES - 1);

    logic          r_run;
    logic [SW-1:0] r_sub;
    logic [2:0]    r_phase;
    logic [SW-1:0] w_nxt_sub;
    logic [2:0]    w_nxt_phase;

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            r_run   <= 1'b0;
            r_sub   <= '0;
            r_phase <= PH_A1;
        end else begin
            r_run   <= 1'b1;
            r_sub   <= w_nxt_sub;
            r_phase <= w_nxt_phase;
        end
    end

    // The first edge after reset only arms the sequencer; it lands on A1 tick 0.
    assign last_tick = r_run && (r_sub == SUB_LAST);

    always_comb begin
        w_nxt_sub   = r_sub;
        w_nxt_phase = r_phase;
        if (r_run) begin
            if (last_tick) begin
                w_nxt_sub   = '0;
                w_nxt_phase = r_phase + 3'd1;
            end else begin
                w_nxt_sub   = r_sub + SW'(1);
            end
        end
    end

    assign phase     = r_phase;
    assign nxt_phase = w_nxt_phase;
    assign nxt_last  = (w_nxt_sub == SUB_LAST);

endmodule

// File: rtl/i4004_bus_initiator.sv
// MCS-4 bus master: runs one instruction per 8-phase cycle and drives the
// multiplexed nibble bus, SYNC and CM lines from registers only.
module i4004_bus_initiator
    import i4004_bus_pkg::*;
#(
    parameter int PHASE_CYCLES = 4
) (
    input  logic       sysclk,
    input  logic       reset_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [3:0] req_opr,
    input  logic [3:0] req_opa,
    input  logic [7:0] req_operand,
    input  logic [3:0] req_acc,
    output logic       rsp_valid,
    output logic [3:0] rsp_data,
    input  logic [3:0] data_in,
    output logic [3:0] data_out,
    output logic       data_oe,
    output logic       sync,
    output logic       cm_rom,
    output logic [3:0] cm_ram,
    output logic [2:0] phase
);

    logic [2:0]  w_phase;
    logic        w_last;
    logic [2:0]  w_nxt_phase;
    logic        w_nxt_last;

    instr_t      r_ir;
    logic [11:0] r_pc;
    logic [3:0]  r_bank;
    logic [3:0]  r_rsp_data;
    logic        r_rsp_valid;
    logic [3:0]  r_data_out;
    logic        r_data_oe;
    logic        r_sync;
    logic        r_cm_rom;
    logic [3:0]  r_cm_ram;
    logic        r_req_ready;

    instr_t      w_req;
    logic        w_src, w_io, w_wr, w_rd, w_dcl;
    logic        w_cyc_end, w_capture;
    logic [3:0]  w_out;
    logic        w_oe, w_rom;
    logic [3:0]  w_ram;

    i4004_phase_seq #(.PHASE_CYCLES(PHASE_CYCLES)) u_seq (
        .sysclk    (sysclk),
        .reset_n   (reset_n),
        .phase     (w_phase),
        .last_tick (w_last),
        .nxt_phase (w_nxt_phase),
        .nxt_last  (w_nxt_last)
    );

    assign w_req     = {req_opr, req_opa, req_operand, req_acc};
    assign w_src     = (r_ir.opr == OPR_SRC) && r_ir.opa[0];
    assign w_io      = (r_ir.opr == OPR_IO);
    assign w_wr      = w_io && !r_ir.opa[3];
    assign w_rd      = w_io && r_ir.opa[3];
    assign w_dcl     = (r_ir.opr == OPR_ACC) && (r_ir.opa == OPA_DCL);
    assign w_cyc_end = w_last && (w_phase == PH_X3);
    assign w_capture = w_last && (w_phase == PH_X2) && w_rd;

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            r_ir        <= NOP_INSTR;
            r_pc        <= '0;
            r_bank      <= 4'b0001;
            r_rsp_data  <= '0;
            r_rsp_valid <= 1'b0;
        end else begin
            r_rsp_valid <= w_capture;
            if (w_capture)
                r_rsp_data <= data_in;
            if (w_last && (w_phase == PH_M2))
                r_pc <= r_pc + 12'd1;
            // Cycle boundary: retire DCL and latch the next instruction (NOP if none offered).
            if (w_cyc_end) begin
                if (w_dcl)
                    r_bank <= bank_sel(r_ir.acc[1:0]);
                r_ir <= (req_valid && r_req_ready) ? w_req : NOP_INSTR;
            end
        end
    end

    // Bus values for the phase the sequencer is about to enter.
    always_comb begin
        w_out = '0;
        w_oe  = 1'b0;
        w_rom = 1'b0;
        w_ram = '0;
        case (w_nxt_phase)
            PH_A1: begin w_out = r_pc[3:0];  w_oe = 1'b1; end
            PH_A2: begin w_out = r_pc[7:4];  w_oe = 1'b1; end
            PH_A3: begin w_out = r_pc[11:8]; w_oe = 1'b1; w_rom = 1'b1; end
            PH_M1: begin w_out = r_ir.opr;   w_oe = 1'b1; end
            PH_M2: begin
                w_out = r_ir.opa;
                w_oe  = 1'b1;
                if (w_io) begin
                    w_rom = 1'b1;
                    w_ram = r_bank;
                end
            end
            PH_X1: begin w_out = r_ir.opa; w_oe = 1'b1; end
            PH_X2: begin
                if (w_src) begin
                    w_out = r_ir.operand[7:4];
                    w_oe  = 1'b1;
                    w_ram = r_bank;
                end else if (w_wr) begin
                    w_out = r_ir.acc;
                    w_oe  = 1'b1;
                end
            end
            PH_X3: begin
                if (w_src) begin
                    w_out = r_ir.operand[3:0];
                    w_oe  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            r_data_out  <= '0;
            r_data_oe   <= 1'b0;
            r_sync      <= 1'b0;
            r_cm_rom    <= 1'b0;
            r_cm_ram    <= '0;
            r_req_ready <= 1'b0;
        end else begin
            r_data_out  <= w_out;
            r_data_oe   <= w_oe;
            r_sync      <= (w_nxt_phase == PH_X3);
            r_cm_rom    <= w_rom;
            r_cm_ram    <= w_ram;
            r_req_ready <= (w_nxt_phase == PH_X3) && w_nxt_last;
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign data_out  = r_data_out;
    assign data_oe   = r_data_oe;
    assign sync      = r_sync;
    assign cm_rom    = r_cm_rom;
    assign cm_ram    = r_cm_ram;
    assign phase     = w_phase;

endmodule

// File: tb/tb_i4004_bus_initiator.sv
// Randomized bench for i4004_bus_initiator: a tick-indexed model derives every
// expected bus value from the cycle number, phase and current instruction.
module tb_i4004_bus_initiator;

    localparam int PC  = 4;
    localparam int CYC = 8 * PC;

    typedef struct packed {
        logic [3:0] opr;
        logic [3:0] opa;
        logic [7:0] operand;
        logic [3:0] acc;
    } req_t;

    logic       sysclk = 1'b0;
    logic       reset_n = 1'b0;
    logic       req_valid = 1'b0;
    logic [3:0] req_opr = '0;
    logic [3:0] req_opa = '0;
    logic [7:0] req_operand = '0;
    logic [3:0] req_acc = '0;
    logic [3:0] data_in = '0;
    logic       req_ready, rsp_valid, data_oe, sync, cm_rom;
    logic [3:0] rsp_data, data_out, cm_ram;
    logic [2:0] phase;

    i4004_bus_initiator #(.PHASE_CYCLES(PC)) dut (
        .sysclk      (sysclk),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_opr     (req_opr),
        .req_opa     (req_opa),
        .req_operand (req_operand),
        .req_acc     (req_acc),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .data_in     (data_in),
        .data_out    (data_out),
        .data_oe     (data_oe),
        .sync        (sync),
        .cm_rom      (cm_rom),
        .cm_ram      (cm_ram),
        .phase       (phase)
    );

    always #5 sysclk = ~sysclk;

    int   checks = 0;
    int   errors = 0;
    int   t;
    req_t m_ins;
    logic [3:0] m_bank;
    logic [3:0] m_rsp;
    bit   first_rd = 1'b1;
    req_t q[$];

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0d: got %0h expected %0h", tag, t, got, exp);
        end
    endtask

    function automatic req_t mk(input logic [3:0] opr, input logic [3:0] opa,
                                input logic [7:0] operand, input logic [3:0] acc);
        req_t r;
        r.opr = opr; r.opa = opa; r.operand = operand; r.acc = acc;
        return r;
    endfunction

    function automatic req_t gen_req();
        req_t r;
        r.opr     = 4'($urandom);
        r.opa     = 4'($urandom);
        r.operand = 8'($urandom);
        r.acc     = 4'($urandom);
        case ($urandom_range(0, 5))
            0:       r.opr = 4'h2;
            1, 2:    r.opr = 4'hE;
            3:       begin r.opr = 4'hF; r.opa = 4'hD; end
            default: ;
        endcase
        return r;
    endfunction

    function automatic bit is_rd(input req_t r);
        return (r.opr == 4'hE) && r.opa[3];
    endfunction

    task automatic check_zero(input string tag);
        chk({tag, "_phase"}, 16'(phase), 16'(0));
        chk({tag, "_data_oe"}, 16'(data_oe), 16'(0));
        chk({tag, "_data_out"}, 16'(data_out), 16'(0));
        chk({tag, "_sync"}, 16'(sync), 16'(0));
        chk({tag, "_cm_rom"}, 16'(cm_rom), 16'(0));
        chk({tag, "_cm_ram"}, 16'(cm_ram), 16'(0));
        chk({tag, "_req_ready"}, 16'(req_ready), 16'(0));
        chk({tag, "_rsp_valid"}, 16'(rsp_valid), 16'(0));
        chk({tag, "_rsp_data"}, 16'(rsp_data), 16'(0));
    endtask

    task automatic check_tick();
        int ph, s;
        logic [11:0] pcv;
        bit src, io, rd, wr;
        logic [3:0] e_out, e_ram;
        logic e_oe, e_rom;
        ph  = (t / PC) % 8;
        s   = t % PC;
        pcv = 12'(t / CYC);
        src = (m_ins.opr == 4'h2) && m_ins.opa[0];
        io  = (m_ins.opr == 4'hE);
        rd  = io && m_ins.opa[3];
        wr  = io && !m_ins.opa[3];
        e_out = '0; e_ram = '0; e_oe = 1'b0; e_rom = 1'b0;
        case (ph)
            0: begin e_oe = 1'b1; e_out = pcv[3:0]; end
            1: begin e_oe = 1'b1; e_out = pcv[7:4]; end
            2: begin e_oe = 1'b1; e_out = pcv[11:8]; e_rom = 1'b1; end
            3: begin e_oe = 1'b1; e_out = m_ins.opr; end
            4: begin
                e_oe = 1'b1; e_out = m_ins.opa;
                if (io) begin e_rom = 1'b1; e_ram = m_bank; end
            end
            5: begin e_oe = 1'b1; e_out = m_ins.opa; end
            6: begin
                if (src) begin e_oe = 1'b1; e_out = m_ins.operand[7:4]; e_ram = m_bank; end
                else if (wr) begin e_oe = 1'b1; e_out = m_ins.acc; end
            end
            default: begin
                if (src) begin e_oe = 1'b1; e_out = m_ins.operand[3:0]; end
            end
        endcase
        chk("phase", 16'(phase), 16'(ph));
        chk("data_oe", 16'(data_oe), 16'(e_oe));
        if (e_oe)
            chk("data_out", 16'(data_out), 16'(e_out));
        chk("cm_rom", 16'(cm_rom), 16'(e_rom));
        chk("cm_ram", 16'(cm_ram), 16'(e_ram));
        chk("sync", 16'(sync), 16'(ph == 7));
        chk("req_ready", 16'(req_ready), 16'((ph == 7) && (s == PC - 1)));
        chk("rsp_valid", 16'(rsp_valid), 16'((ph == 7) && (s == 0) && rd));
        chk("rsp_data", 16'(rsp_data), 16'(m_rsp));
    endtask

    // Called at a negedge: check this tick, drive inputs, advance the model over the edge.
    task automatic step();
        int ph, s;
        req_t r;
        bit from_q;
        ph = (t / PC) % 8;
        s  = t % PC;
        r  = '0;
        check_tick();
        req_valid = 1'($urandom);
        {req_opr, req_opa, req_operand, req_acc} = 20'($urandom);
        if (ph == 7 && s == PC - 1) begin
            from_q = (q.size() > 0);
            if (from_q) r = q.pop_front();
            else        r = gen_req();
            req_valid = from_q || ($urandom_range(0, 3) != 0);
            if (req_valid)
                {req_opr, req_opa, req_operand, req_acc} = r;
        end
        data_in = 4'($urandom);
        if (ph == 6 && is_rd(m_ins) && first_rd)
            data_in = 4'hC;
        @(posedge sysclk);
        if (ph == 6 && s == PC - 1 && is_rd(m_ins)) begin
            m_rsp    = data_in;
            first_rd = 1'b0;
        end
        if (ph == 7 && s == PC - 1) begin
            if (m_ins.opr == 4'hF && m_ins.opa == 4'hD)
                m_bank = 4'b0001 << m_ins.acc[1:0];
            m_ins = req_valid ? r : '0;
        end
        t++;
        @(negedge sysclk);
    endtask

    task automatic model_reset();
        t      = 0;
        m_ins  = '0;
        m_bank = 4'b0001;
        m_rsp  = 4'h0;
    endtask

    initial begin
        bit found;
        model_reset();
        repeat (3) @(negedge sysclk);
        check_zero("reset");
        reset_n = 1'b1;
        @(posedge sysclk);
        @(negedge sysclk);

        q.push_back(mk(4'h2, 4'h1, 8'h4A, 4'h0));
        q.push_back(mk(4'hF, 4'hD, 8'h00, 4'h2));
        q.push_back(mk(4'h2, 4'h3, 8'h5B, 4'h0));
        q.push_back(mk(4'hE, 4'h0, 8'h00, 4'h7));
        q.push_back(mk(4'hE, 4'h9, 8'h00, 4'h0));
        for (int i = 0; i < 7 * CYC; i++) step();
        for (int i = 0; i < 40 * CYC; i++) step();

        // Abort a read in the middle of X2.
        q.push_back(mk(4'hE, 4'h9, 8'h00, 4'h0));
        found = 1'b0;
        for (int i = 0; i < 3 * CYC; i++) begin
            if (is_rd(m_ins) && ((t / PC) % 8) == 6 && (t % PC) == 1) begin
                found = 1'b1;
                break;
            end
            step();
        end
        chk("abort_reached_x2", 16'(found), 16'(1));
        reset_n = 1'b0;
        #1;
        check_zero("abort");
        repeat (2) begin
            @(negedge sysclk);
            chk("abort_rsp_valid", 16'(rsp_valid), 16'(0));
            chk("abort_phase", 16'(phase), 16'(0));
            chk("abort_data_oe", 16'(data_oe), 16'(0));
        end
        model_reset();
        reset_n = 1'b1;
        @(posedge sysclk);
        @(negedge sysclk);
        q.push_back(mk(4'h2, 4'h1, 8'hC3, 4'h0));
        for (int i = 0; i < 20 * CYC; i++) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
